// File: rtl/bit_scan_pkg.sv
// rtl/bit_scan_pkg.sv - shared types, defaults and chunk helpers for bit_scan_counter
// Purpose: state/mode enums, default geometry, and the per-chunk popcount and
//          leading-zero helpers used by the datapath.
// Ports:   none (package).
package bit_scan_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        M_ONES  = 2'b00,
        M_ZEROS = 2'b01,
        M_LZ    = 2'b10,
        M_TZ    = 2'b11
    } mode_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_STEP   = 1;

    // Widest chunk the helpers accept; chunks are zero-extended into this.
    localparam int MAX_STEP = 64;

    function automatic int popcount_step(input logic [MAX_STEP-1:0] chunk);
        int sum;
        sum = 0;
        for (int i = 0; i < MAX_STEP; i++) begin
            if (chunk[i]) sum = sum + 1;
        end
        return sum;
    endfunction

    // Leading zeros of the low 'step' bits of chunk, counted from bit step-1 down.
    function automatic int lzc_step(input logic [MAX_STEP-1:0] chunk, input int step);
        int  cnt;
        logic found;
        cnt   = 0;
        found = 1'b0;
        for (int i = MAX_STEP - 1; i >= 0; i--) begin
            if (i < step && !found) begin
                if (chunk[i]) found = 1'b1;
                else          cnt   = cnt + 1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bit_scan_datapath.sv
// rtl/bit_scan_datapath.sv - operand/result registers and chunk adder for bit_scan_counter
// Purpose: holds R1 (operand being scanned), R2 (running count) and the latched
//          scan direction; conditions the operand at load and adds one chunk's
//          contribution per step.
// Ports:   clk, rst_b        clock, async active-low reset
//          load_regs         load R1 from conditioned data_in, clear R2
//          shift             shift R1 by STEP (right for popcount, left for lz)
//          incr_r2           add the current chunk contribution to R2
//          mode, data_in     operand and mode, used only on load_regs
//          lz_mode           latched mode is a leading/trailing-zero mode
//          r1_zero           R1 has no bits left set
//          chunk_hit         MSB-side chunk of R1 contains a 1
//          cnt               R2
module bit_scan_datapath
    import bit_scan_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int STEP   = DEF_STEP,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              load_regs,
    input  logic              shift,
    input  logic              incr_r2,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data_in,
    output logic              lz_mode,
    output logic              r1_zero,
    output logic              chunk_hit,
    output logic [CNT_W-1:0]  cnt
);

    logic [DATA_W-1:0]   r1;
    logic [DATA_W-1:0]   r1_load;
    logic [CNT_W-1:0]    r2;
    logic [CNT_W-1:0]    r2_inc;
    logic                lz_q;
    logic [MAX_STEP-1:0] lo_ext;
    logic [MAX_STEP-1:0] hi_ext;

    // Zeros are counted as ones of the inverted word; trailing zeros are
    // leading zeros of the bit-reversed word, so only two scan engines exist.
    always_comb begin
        r1_load = data_in;
        case (mode_t'(mode))
            M_ZEROS: r1_load = ~data_in;
            M_TZ: begin
                for (int i = 0; i < DATA_W; i++) r1_load[i] = data_in[DATA_W-1-i];
            end
            default: r1_load = data_in;
        endcase
    end

    always_comb begin
        lo_ext = '0;
        hi_ext = '0;
        lo_ext[STEP-1:0] = r1[STEP-1:0];
        hi_ext[STEP-1:0] = r1[DATA_W-1 -: STEP];
    end

    assign chunk_hit = |r1[DATA_W-1 -: STEP];
    assign r1_zero   = (r1 == '0);

    always_comb begin
        if (!lz_q)         r2_inc = CNT_W'(popcount_step(lo_ext));
        else if (chunk_hit) r2_inc = CNT_W'(lzc_step(hi_ext, STEP));
        else                r2_inc = CNT_W'(STEP);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r1   <= '0;
            r2   <= '0;
            lz_q <= 1'b0;
        end else if (load_regs) begin
            r1   <= r1_load;
            r2   <= '0;
            lz_q <= mode[1];
        end else begin
            if (incr_r2) r2 <= r2 + r2_inc;
            if (shift)   r1 <= lz_q ? (r1 << STEP) : (r1 >> STEP);
        end
    end

    assign lz_mode = lz_q;
    assign cnt     = r2;

endmodule

// File: rtl/bit_scan_counter.sv
// rtl/bit_scan_counter.sv - multi-cycle ones/zeros/leading/trailing-zero counter
// Purpose: controller (FSM, step counter, done flop) plus bit_scan_datapath.
//          Scans STEP bits per cycle and stops as soon as the count is known.
// Ports:   clk, rst_b        clock, async active-low reset
//          start             request, taken only while rdy=1
//          mode              00 ones, 01 zeros, 10 leading zeros, 11 trailing zeros
//          data_in           operand, sampled with start
//          cnt               result, valid while rdy=1
//          rdy               idle and able to accept start
//          done              one-cycle pulse on the first idle cycle after a run
module bit_scan_counter
    import bit_scan_pkg::*;
#(
    parameter int    DATA_W = DEF_DATA_W,
    parameter int    STEP   = DEF_STEP,
    localparam int   CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data_in,
    output logic [CNT_W-1:0]  cnt,
    output logic              rdy,
    output logic              done
);

    if (STEP < 1 || (DATA_W % STEP) != 0) begin : g_bad_step
        $error("bit_scan_counter: STEP must be >= 1 and divide DATA_W");
    end

    localparam int CHUNKS  = (STEP > 0) ? DATA_W / STEP : 1;
    localparam int STEPS_W = $clog2(CHUNKS + 1);

    state_t             state;
    state_t             state_nxt;
    logic [STEPS_W-1:0] steps;
    logic               done_q;
    logic               load_regs;
    logic               shift;
    logic               incr_r2;
    logic               zero;
    logic               last_step;
    logic               lz_mode;
    logic               r1_zero;
    logic               chunk_hit;

    assign rdy       = (state == S_IDLE);
    assign load_regs = rdy && start;
    // Popcount run is finished once no set bits remain; that cycle adds nothing.
    assign zero      = (state == S_RUN) && !lz_mode && r1_zero;
    assign last_step = (steps == STEPS_W'(CHUNKS - 1));

    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        incr_r2   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!lz_mode) begin
                    if (zero) begin
                        state_nxt = S_IDLE;
                    end else begin
                        shift   = 1'b1;
                        incr_r2 = 1'b1;
                    end
                end else begin
                    // A hit chunk adds its internal leading zeros; an empty
                    // chunk adds STEP. The last chunk ends the run either way.
                    incr_r2 = 1'b1;
                    shift   = !chunk_hit;
                    if (chunk_hit || last_step) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= S_IDLE;
            steps  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == S_RUN) && (state_nxt == S_IDLE);
            if (load_regs)              steps <= '0;
            else if (shift && lz_mode) steps <= steps + STEPS_W'(1);
        end
    end

    assign done = done_q;

    bit_scan_datapath #(
        .DATA_W (DATA_W),
        .STEP   (STEP),
        .CNT_W  (CNT_W)
    ) u_dp (
        .clk       (clk),
        .rst_b     (rst_b),
        .load_regs (load_regs),
        .shift     (shift),
        .incr_r2   (incr_r2),
        .mode      (mode),
        .data_in   (data_in),
        .lz_mode   (lz_mode),
        .r1_zero   (r1_zero),
        .chunk_hit (chunk_hit),
        .cnt       (cnt)
    );

endmodule

// File: tb/tb_bit_scan_counter.sv
// tb/tb_bit_scan_counter.sv - scoreboard bench for bit_scan_counter
module tb_bit_scan_counter;

    typedef struct {
        int     cnt;
        int     lat;
        longint t0;
    } exp_t;

    int total = 0;
    int bad   = 0;

    logic   clk = 1'b0;
    longint cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_m  = 1'b1;
    logic rst_sw = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: counts straight from the definitions, latency from the
    // chunk-position formulas.
    function automatic void model(input int st, input logic [1:0] md, input logic [7:0] d,
                                  output int c, output int l);
        logic [7:0] w;
        int         hi;
        int         z;
        int         b;
        logic       found;
        int         chunks;
        chunks = 8 / st;
        if (md[1] == 1'b0) begin
            w  = md[0] ? ~d : d;
            c  = $countones(w);
            hi = -1;
            for (int i = 0; i < 8; i++) if (w[i]) hi = i;
            l  = (hi < 0) ? 1 : hi / st + 2;
        end else begin
            z     = 0;
            found = 1'b0;
            for (int i = 0; i < 8; i++) begin
                b = md[0] ? i : 7 - i;
                if (!found) begin
                    if (d[b]) found = 1'b1;
                    else      z++;
                end
            end
            c = z;
            l = (z == 8) ? chunks : z / st + 1;
        end
    endfunction

    // ---------------- main instance, STEP=2 ----------------
    logic       start_m = 1'b0;
    logic [1:0] mode_m  = 2'b00;
    logic [7:0] data_m  = 8'h00;
    logic [3:0] cnt_m;
    logic       rdy_m;
    logic       done_m;
    exp_t       exp_m[$];
    exp_t       em;

    bit_scan_counter #(.DATA_W(8), .STEP(2)) dut (
        .clk     (clk),
        .rst_b   (rst_m),
        .start   (start_m),
        .mode    (mode_m),
        .data_in (data_m),
        .cnt     (cnt_m),
        .rdy     (rdy_m),
        .done    (done_m)
    );

    always @(negedge clk) begin
        if (rst_m && done_m) begin
            if (exp_m.size() == 0) begin
                check("main_unexpected_done", 1, 0);
            end else begin
                em = exp_m.pop_front();
                check("main_cnt", int'(cnt_m), em.cnt);
                check("main_latency", int'(cyc - em.t0), em.lat);
                check("main_rdy_with_done", int'(rdy_m), 1);
            end
        end
    end

    task automatic issue_m(input logic [1:0] md, input logic [7:0] d, input int ec, input int el);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy_m && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy_m) begin
            check("main_rdy_timeout", 0, 1);
        end else begin
            start_m = 1'b1;
            mode_m  = md;
            data_m  = d;
            exp_m.push_back(exp_t'{ec, el, cyc + 1});
            @(negedge clk);
            start_m = 1'b0;
            mode_m  = 2'($urandom);
            data_m  = 8'($urandom);
        end
    endtask

    task automatic drain_m();
        int guard;
        guard = 0;
        while (exp_m.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("main_drain_left", exp_m.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- sweep instances, STEP=1,2,4,8 ----------------
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int ST = 1 << g;
        logic       start_s = 1'b0;
        logic [1:0] mode_s  = 2'b00;
        logic [7:0] data_s  = 8'h00;
        logic [3:0] cnt_s;
        logic       rdy_s;
        logic       done_s;
        exp_t       q[$];
        exp_t       es;
        bit         fin = 1'b0;

        bit_scan_counter #(.DATA_W(8), .STEP(ST)) dut_s (
            .clk     (clk),
            .rst_b   (rst_sw),
            .start   (start_s),
            .mode    (mode_s),
            .data_in (data_s),
            .cnt     (cnt_s),
            .rdy     (rdy_s),
            .done    (done_s)
        );

        always @(negedge clk) begin
            if (rst_sw && done_s) begin
                if (q.size() == 0) begin
                    check($sformatf("sweep_step%0d_unexpected_done", ST), 1, 0);
                end else begin
                    es = q.pop_front();
                    check($sformatf("sweep_step%0d_cnt", ST), int'(cnt_s), es.cnt);
                    check($sformatf("sweep_step%0d_latency", ST), int'(cyc - es.t0), es.lat);
                end
            end
        end

        initial begin
            repeat (3) @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                for (int d = 0; d < 256; d++) begin
                    int guard;
                    int c;
                    int l;
                    guard = 0;
                    @(negedge clk);
                    while (!rdy_s && guard < 200) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (!rdy_s) begin
                        check($sformatf("sweep_step%0d_rdy_timeout", ST), 0, 1);
                    end else begin
                        start_s = 1'b1;
                        mode_s  = 2'(m);
                        data_s  = 8'(d);
                        model(ST, 2'(m), 8'(d), c, l);
                        q.push_back(exp_t'{c, l, cyc + 1});
                        @(negedge clk);
                        start_s = 1'b0;
                        data_s  = 8'($urandom);
                        mode_s  = 2'($urandom);
                    end
                end
            end
            repeat (20) @(negedge clk);
            check($sformatf("sweep_step%0d_drain_left", ST), q.size(), 0);
            fin = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int c;
        int l;
        int seen;
        int guard;
        logic [1:0] md;
        logic [7:0] d;

        #2;
        rst_m  = 1'b0;
        rst_sw = 1'b0;
        #1;
        check("reset_cnt", int'(cnt_m), 0);
        check("reset_rdy", int'(rdy_m), 1);
        check("reset_done", int'(done_m), 0);
        @(negedge clk);
        rst_m  = 1'b1;
        rst_sw = 1'b1;

        issue_m(2'b00, 8'hB5, 5, 5);
        issue_m(2'b01, 8'hFF, 0, 1);
        issue_m(2'b10, 8'h13, 3, 2);
        issue_m(2'b10, 8'h00, 8, 4);
        issue_m(2'b11, 8'h00, 8, 4);
        issue_m(2'b11, 8'h40, 6, 4);
        drain_m();

        for (int k = 0; k < 40; k++) begin
            md = 2'($urandom);
            d  = 8'($urandom);
            model(2, md, d, c, l);
            issue_m(md, d, c, l);
        end
        drain_m();

        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start_m = 1'b1;
            mode_m  = 2'($urandom);
            data_m  = 8'($urandom);
            if (rdy_m) begin
                model(2, mode_m, data_m, c, l);
                exp_m.push_back(exp_t'{c, l, cyc + 1});
            end
        end
        @(negedge clk);
        start_m = 1'b0;
        drain_m();

        start_m = 1'b1;
        mode_m  = 2'b00;
        data_m  = 8'hFF;
        @(negedge clk);
        start_m = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_m = 1'b0;
        #1;
        check("midrun_reset_cnt", int'(cnt_m), 0);
        check("midrun_reset_rdy", int'(rdy_m), 1);
        check("midrun_reset_done", int'(done_m), 0);
        @(negedge clk);
        rst_m = 1'b1;
        seen  = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_m) seen++;
        end
        check("no_done_after_reset", seen, 0);

        issue_m(2'b00, 8'hB5, 5, 5);
        drain_m();

        guard = 0;
        while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin) && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        check("sweep_finished", int'(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
